// File: rtl/s_pipe_reg.sv
// s_pipe_reg: DEPTH-stage valid/ready register slice.
// Each stage holds one beat. Empty stages ("bubbles") close up whenever the
// output is stalled, so a stalled pipe still fills completely. out_valid and
// out_data come straight from the last stage's registers. count tracks how
// many stages currently hold a beat.

`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

module s_pipe_reg #(
  parameter int               WIDTH   = `WORD_WIDTH,
  parameter int               DEPTH   = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  input  logic                       out_ready,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH+1);

  // Stage state. Index 0 is the input stage and DEPTH-1 is the output stage.
  logic [DEPTH-1:0] vld_reg;
  logic [WIDTH-1:0] dat_reg [DEPTH];
  logic [CW-1:0]    count_reg;

  // Next-state terms, one element per stage.
  logic [DEPTH-1:0] vld_next;
  logic [DEPTH-1:0] stage_adv;
  logic [DEPTH-1:0] dat_load;
  logic [WIDTH-1:0] dat_next [DEPTH];
  logic [CW-1:0]    count_next;

  logic accept;
  logic emit;

  // A stage may move forward unless it and every stage ahead of it is
  // occupied while the output is stalled. Writing it as a reduction over the
  // occupied stages, rather than as a chain from stage to stage, keeps the
  // ready path free of a combinational loop through the adv vector.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      assign stage_adv[gi] = out_ready || !(&vld_reg[DEPTH-1:gi]);

      if (gi == 0) begin : g_head
        // The input stage takes the upstream beat. Its payload register is
        // written only when a beat really arrives, so idle cycles do not
        // toggle it. accept already implies that stage 0 is advancing.
        assign vld_next[gi] = stage_adv[gi] ? accept : vld_reg[gi];
        assign dat_load[gi] = accept;
        assign dat_next[gi] = in_data;
      end else begin : g_body
        // Later stages take the beat from the stage behind them. When a
        // bubble moves in, the valid flag clears but the payload is kept.
        assign vld_next[gi] = stage_adv[gi] ? vld_reg[gi-1] : vld_reg[gi];
        assign dat_load[gi] = stage_adv[gi] && vld_reg[gi-1];
        assign dat_next[gi] = dat_reg[gi-1];
      end
    end
  endgenerate

  // Handshake terms. During reset or flush nothing is accepted, even when
  // stage 0 could otherwise advance.
  assign in_ready = stage_adv[0] && !flush && !rst;
  assign accept   = in_valid && in_ready;
  assign emit     = vld_reg[DEPTH-1] && out_ready;

  // Occupancy changes only when exactly one of accept and emit happens.
  always_comb begin
    count_next = count_reg;
    if (accept && !emit) begin
      count_next = count_reg + CW'(1);
    end else if (!accept && emit) begin
      count_next = count_reg - CW'(1);
    end
  end

  // State update. Reset and flush clear the pipe in the same way. A beat
  // emitted in a flush cycle has already left through the handshake, so
  // clearing the stages does not lose it.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      vld_reg   <= '0;
      count_reg <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        dat_reg[i] <= RST_VAL;
      end
    end else begin
      vld_reg   <= vld_next;
      count_reg <= count_next;
      for (int i = 0; i < DEPTH; i++) begin
        if (dat_load[i]) begin
          dat_reg[i] <= dat_next[i];
        end
      end
    end
  end

  // Outputs come directly from the registers.
  assign out_valid = vld_reg[DEPTH-1];
  assign out_data  = dat_reg[DEPTH-1];
  assign count     = count_reg;

endmodule

// File: tb/tb_s_pipe_reg.sv
// Testbench for s_pipe_reg: directed tables for a DEPTH=3 and a DEPTH=1
// instance, then randomized traffic on the DEPTH=3 instance checked against
// a queue-of-beats reference model.

module tb_s_pipe_reg;

  localparam int          D3   = 3;
  localparam logic [31:0] RV3  = 32'hA5A5_5A5A;
  localparam logic [31:0] RV1  = 32'h0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DEPTH=3 instance signals
  logic        rst = 1'b0, flush = 1'b0, iv = 1'b0, ordy = 1'b0;
  logic [31:0] id = '0;
  logic        ir, ov;
  logic [31:0] od;
  logic [1:0]  cnt;

  // DEPTH=1 instance signals
  logic        d1_rst = 1'b0, d1_flush = 1'b0, d1_iv = 1'b0, d1_ordy = 1'b0;
  logic [31:0] d1_id = '0;
  logic        d1_ir, d1_ov;
  logic [31:0] d1_od;
  logic [0:0]  d1_cnt;

  s_pipe_reg #(.WIDTH(32), .DEPTH(3), .RST_VAL(RV3)) dut3 (
    .clk(clk), .rst(rst), .in_valid(iv), .in_data(id), .in_ready(ir),
    .out_valid(ov), .out_data(od), .out_ready(ordy), .flush(flush), .count(cnt)
  );

  s_pipe_reg #(.WIDTH(32), .DEPTH(1)) dut1 (
    .clk(clk), .rst(d1_rst), .in_valid(d1_iv), .in_data(d1_id), .in_ready(d1_ir),
    .out_valid(d1_ov), .out_data(d1_od), .out_ready(d1_ordy), .flush(d1_flush),
    .count(d1_cnt)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // One directed vector: inputs for one cycle, in_ready during that cycle,
  // and the registered outputs right after the following rising edge.
  typedef struct {
    logic        rst, flush, iv;
    logic [31:0] id;
    logic        ordy;
    logic        ir, ov;
    logic [31:0] od;
    int          cnt;
  } vec_t;

  function automatic vec_t mk(logic r, logic f, logic v, logic [31:0] d, logic o,
                              logic eir, logic eov, logic [31:0] eod, int ecnt);
    vec_t x;
    x.rst = r; x.flush = f; x.iv = v; x.id = d; x.ordy = o;
    x.ir = eir; x.ov = eov; x.od = eod; x.cnt = ecnt;
    return x;
  endfunction

  task automatic apply_vec(input int sel, input int idx, input vec_t v);
    logic        a_ir, a_ov;
    logic [31:0] a_od, a_cnt;
    @(negedge clk);
    if (sel == 1) begin
      d1_rst = v.rst; d1_flush = v.flush; d1_iv = v.iv; d1_id = v.id; d1_ordy = v.ordy;
    end else begin
      rst = v.rst; flush = v.flush; iv = v.iv; id = v.id; ordy = v.ordy;
    end
    #1;
    a_ir = (sel == 1) ? d1_ir : ir;
    chk($sformatf("d%0d_vec%0d_in_ready", sel, idx), {31'b0, a_ir}, {31'b0, v.ir});
    @(posedge clk);
    #1;
    a_ov  = (sel == 1) ? d1_ov : ov;
    a_od  = (sel == 1) ? d1_od : od;
    a_cnt = (sel == 1) ? {31'b0, d1_cnt} : {30'b0, cnt};
    chk($sformatf("d%0d_vec%0d_out_valid", sel, idx), {31'b0, a_ov}, {31'b0, v.ov});
    chk($sformatf("d%0d_vec%0d_out_data", sel, idx), a_od, v.od);
    chk($sformatf("d%0d_vec%0d_count", sel, idx), a_cnt, v.cnt);
    $display("vec d%0d #%0d rst=%0b fl=%0b iv=%0b id=%h ordy=%0b -> ir=%0b ov=%0b od=%h cnt=%0d",
             sel, idx, v.rst, v.flush, v.iv, v.id, v.ordy, a_ir, a_ov, a_od, a_cnt);
  endtask

  // Reference model: the pipe as an ordered list of beats, each at a stage
  // position. A beat moves forward whenever the position ahead of it is free
  // after the beats in front have moved. out_data is the payload of the most
  // recent beat that reached the last position since the last clear.
  typedef struct {
    int          pos;
    logic [31:0] data;
  } mbeat_t;

  mbeat_t      mq[$];
  logic [31:0] m_od = RV3;

  function automatic logic model_ir(logic r, logic f, logic o);
    return ((mq.size() < D3) || o) && !f && !r;
  endfunction

  task automatic model_step(input logic r, input logic f, input logic v,
                            input logic [31:0] d, input logic o);
    logic   acc;
    int     limit;
    mbeat_t b;
    if (r || f) begin
      mq.delete();
      m_od = RV3;
    end else begin
      acc = v && model_ir(r, f, o);
      if (mq.size() > 0 && mq[0].pos == D3 - 1 && o) void'(mq.pop_front());
      limit = D3;
      for (int i = 0; i < mq.size(); i++) begin
        b = mq[i];
        if (b.pos + 1 < limit) b.pos = b.pos + 1;
        mq[i] = b;
        limit = b.pos;
      end
      if (acc) begin
        b.pos = 0;
        b.data = d;
        mq.push_back(b);
      end
      if (mq.size() > 0 && mq[0].pos == D3 - 1) m_od = mq[0].data;
    end
  endtask

  vec_t tab3[32];
  vec_t tab1[8];

  initial begin
    // DEPTH=3: rst, flush, iv, id, ordy | in_ready, out_valid, out_data, count
    tab3[0]  = mk(1, 0, 0, 32'h0,  0, 0, 0, RV3,    0);
    // back-to-back 0x11,0x22,0x33 with out_ready=1: 3-cycle latency
    tab3[1]  = mk(0, 0, 1, 32'h11, 1, 1, 0, RV3,    1);
    tab3[2]  = mk(0, 0, 1, 32'h22, 1, 1, 0, RV3,    2);
    tab3[3]  = mk(0, 0, 1, 32'h33, 1, 1, 1, 32'h11, 3);
    tab3[4]  = mk(0, 0, 0, 32'h0,  1, 1, 1, 32'h22, 2);
    tab3[5]  = mk(0, 0, 0, 32'h0,  1, 1, 1, 32'h33, 1);
    tab3[6]  = mk(0, 0, 0, 32'h0,  1, 1, 0, 32'h33, 0);
    // stalled output: three beats fill the pipe, the fourth is refused
    tab3[7]  = mk(0, 0, 1, 32'h44, 0, 1, 0, 32'h33, 1);
    tab3[8]  = mk(0, 0, 1, 32'h55, 0, 1, 0, 32'h33, 2);
    tab3[9]  = mk(0, 0, 1, 32'h66, 0, 1, 1, 32'h44, 3);
    tab3[10] = mk(0, 0, 1, 32'h77, 0, 0, 1, 32'h44, 3);
    tab3[11] = mk(0, 0, 1, 32'h77, 0, 0, 1, 32'h44, 3);
    // full with out_ready=1: one in and one out in the same cycle, then drain
    tab3[12] = mk(0, 0, 1, 32'h77, 1, 1, 1, 32'h55, 3);
    tab3[13] = mk(0, 0, 0, 32'h0,  1, 1, 1, 32'h66, 2);
    tab3[14] = mk(0, 0, 0, 32'h0,  1, 1, 1, 32'h77, 1);
    tab3[15] = mk(0, 0, 0, 32'h0,  1, 1, 0, 32'h77, 0);
    // 0xA, bubble, 0xB while stalled: the bubble closes up, then both drain
    tab3[16] = mk(0, 0, 1, 32'hA,  0, 1, 0, 32'h77, 1);
    tab3[17] = mk(0, 0, 0, 32'h0,  0, 1, 0, 32'h77, 1);
    tab3[18] = mk(0, 0, 1, 32'hB,  0, 1, 1, 32'hA,  2);
    tab3[19] = mk(0, 0, 0, 32'h0,  0, 1, 1, 32'hA,  2);
    tab3[20] = mk(0, 0, 0, 32'h0,  0, 1, 1, 32'hA,  2);
    tab3[21] = mk(0, 0, 0, 32'h0,  1, 1, 1, 32'hB,  1);
    tab3[22] = mk(0, 0, 0, 32'h0,  1, 1, 0, 32'hB,  0);
    // count=2, then flush with in_valid=1: cleared and the beat is refused
    tab3[23] = mk(0, 0, 1, 32'hC1, 0, 1, 0, 32'hB,  1);
    tab3[24] = mk(0, 0, 1, 32'hC2, 0, 1, 0, 32'hB,  2);
    tab3[25] = mk(0, 1, 1, 32'hC3, 0, 0, 0, RV3,    0);
    tab3[26] = mk(0, 0, 0, 32'h0,  0, 1, 0, RV3,    0);
    // full pipe, then reset and flush together
    tab3[27] = mk(0, 0, 1, 32'h01, 0, 1, 0, RV3,    1);
    tab3[28] = mk(0, 0, 1, 32'h02, 0, 1, 0, RV3,    2);
    tab3[29] = mk(0, 0, 1, 32'h03, 0, 1, 1, 32'h01, 3);
    tab3[30] = mk(1, 1, 1, 32'h04, 0, 0, 0, RV3,    0);
    tab3[31] = mk(0, 0, 0, 32'h0,  0, 1, 0, RV3,    0);

    // DEPTH=1: 1-cycle latency, full throughput, stall and flush
    tab1[0] = mk(1, 0, 0, 32'h0,  0, 0, 0, RV1,    0);
    tab1[1] = mk(0, 0, 1, 32'h11, 1, 1, 1, 32'h11, 1);
    tab1[2] = mk(0, 0, 1, 32'h22, 1, 1, 1, 32'h22, 1);
    tab1[3] = mk(0, 0, 1, 32'h33, 1, 1, 1, 32'h33, 1);
    tab1[4] = mk(0, 0, 0, 32'h0,  1, 1, 0, 32'h33, 0);
    tab1[5] = mk(0, 0, 1, 32'h44, 0, 1, 1, 32'h44, 1);
    tab1[6] = mk(0, 0, 1, 32'h55, 0, 0, 1, 32'h44, 1);
    tab1[7] = mk(0, 1, 1, 32'h55, 1, 0, 0, RV1,    0);

    for (int i = 0; i < 32; i++) apply_vec(3, i, tab3[i]);
    for (int i = 0; i < 8; i++)  apply_vec(1, i, tab1[i]);

    // Randomized traffic on the DEPTH=3 instance. The first cycle is a
    // reset so that the model and the DUT start from the same state.
    for (int c = 0; c < 1500; c++) begin
      logic        r_r, r_f, r_v, r_o, e_ir;
      logic [31:0] r_d;
      r_r = (c == 0) || ($urandom_range(0, 149) == 0);
      r_f = ($urandom_range(0, 39) == 0);
      r_v = ($urandom_range(0, 3) != 0);
      r_d = $urandom;
      // alternate between stall-heavy and flowing phases
      r_o = ((c / 64) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      @(negedge clk);
      rst = r_r; flush = r_f; iv = r_v; id = r_d; ordy = r_o;
      #1;
      e_ir = model_ir(r_r, r_f, r_o);
      chk($sformatf("rnd%0d_in_ready", c), {31'b0, ir}, {31'b0, e_ir});
      @(posedge clk);
      model_step(r_r, r_f, r_v, r_d, r_o);
      #1;
      chk($sformatf("rnd%0d_out_valid", c), {31'b0, ov},
          {31'b0, (mq.size() > 0 && mq[0].pos == D3 - 1)});
      chk($sformatf("rnd%0d_out_data", c), od, m_od);
      chk($sformatf("rnd%0d_count", c), {30'b0, cnt}, mq.size());
      $display("rnd %0d rst=%0b fl=%0b iv=%0b id=%h ordy=%0b -> ov=%0b od=%h cnt=%0d",
               c, r_r, r_f, r_v, r_d, r_o, ov, od, cnt);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/s_pipe_reg.md
S_PIPE_REG -- requirements
Module: s_pipe_reg

Interface
REQ-001 Parameter WIDTH, default `WORD_WIDTH, payload bit width (>=1).
REQ-002 Parameter DEPTH, default 2, number of register stages (>=1).
REQ-003 Parameter RST_VAL, default 0, WIDTH-bit value loaded into every data register on reset and flush.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset.
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 in_valid  input  1  upstream beat present.
REQ-008 in_data  input  WIDTH  upstream payload.
REQ-009 in_ready  output  1  block accepts beat this cycle (combinational).
REQ-010 out_valid  output  1  last stage holds a beat (registered).
REQ-011 out_data  output  WIDTH  last-stage payload (registered).
REQ-012 out_ready  input  1  downstream accepts beat.
REQ-013 flush  input  1  discard all held beats.
REQ-014 count  output  $clog2(DEPTH+1)  number of valid stages (registered).

Function
REQ-015 Stages numbered 0 (input) to DEPTH-1 (output); each holds vld[i] and dat[i].
REQ-016 Handshake: beat transfers in when in_valid && in_ready; out when out_valid && out_ready.
REQ-017 Stage i SHALL advance when vld[i]=0 or stage i+1 advances; stage DEPTH-1 advances when vld=0 or out_ready=1.
REQ-018 in_ready SHALL equal (stage 0 advances) && !flush && !rst.
REQ-019 On advance, stage i SHALL load vld/dat of stage i-1 (stage 0 loads in_valid&&in_ready / in_data).
REQ-020 A non-advancing stage SHALL hold dat and vld unchanged; out_data SHALL be stable while out_valid && !out_ready.
REQ-021 Data registers of a stage receiving a bubble SHALL hold prior value (no payload toggling on bubbles).
REQ-022 Latency with no stall: beat accepted in cycle N SHALL appear on out_valid/out_data in cycle N+DEPTH.
REQ-023 Throughput: with out_ready held 1, one beat per cycle SHALL be sustained indefinitely.
REQ-024 Full (count=DEPTH) and out_ready=1: in_ready=1, simultaneous accept and emit, count unchanged.
REQ-025 Full and out_ready=0: in_ready=0, all stages hold.
REQ-026 Bubbles SHALL collapse: a stalled output allows upstream stages with vld=0 to fill.
REQ-027 count SHALL update by +1 on accept only, -1 on emit only, 0 on both or neither; never exceed DEPTH.
REQ-028 flush=1: next cycle all vld=0, all dat=RST_VAL, count=0; beat at out in flush cycle is still counted as emitted if out_ready=1; input beat in flush cycle SHALL NOT be accepted.
REQ-029 rst has priority over flush; flush over normal operation.
REQ-030 out_valid/out_data SHALL be driven directly from stage DEPTH-1 registers.

Reset
REQ-031 While rst=1 at a clock edge: all vld=0, all dat=RST_VAL, count=0.
REQ-032 After reset: out_valid=0, out_data=RST_VAL, count=0, in_ready=1 once rst=0 (combinational).
REQ-033 Reset mid-transfer SHALL drop all held beats; no beat emitted in the reset cycle counts.

Verification
REQ-034 WIDTH=32, DEPTH=3, out_ready=1, in_data=0x11,0x22,0x33 on consecutive cycles from N -> out_data 0x11,0x22,0x33 at N+3..N+5, count peaks 3.
REQ-035 DEPTH=3, out_ready=0, push 4 beats -> first 3 accepted, in_ready=0 on 4th, count=3, out_data=first beat stable.
REQ-036 Full, out_ready=1 and in_valid=1 same cycle -> one in, one out, count stays 3, order preserved.
REQ-037 Beats 0xA,bubble,0xB with out_ready=0 then 1 -> bubble collapsed, count=2, 0xA then 0xB on consecutive cycles.
REQ-038 count=2, flush=1 with in_valid=1 -> next cycle count=0, out_valid=0, out_data=RST_VAL, input beat not accepted.
REQ-039 rst=1 asserted with count=3 and flush=1 -> next cycle all cleared; DEPTH=1 run of REQ-034 gives 1-cycle latency.
